// File: rtl/post_lna_pkg.sv
// Shared types and helpers for the post-LNA channel array: channel states,
// default guard length and the saturating gain shift.
package post_lna_pkg;

  typedef enum logic [1:0] {
    RX    = 2'd0,
    RX2TX = 2'd1,
    TX    = 2'd2,
    TX2RX = 2'd3
  } lna_state_e;

  localparam int DEFAULT_GUARD = 3;
  localparam int CNT_W         = 4;
  localparam int SAT_W         = 16;

  // x is a sign-extended sample of 'width' bits; the result is clamped to the
  // signed range of 'width' bits and returned sign-extended to SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] x,
    input logic [1:0]              sh,
    input int                      width
  );
    logic signed [SAT_W+3:0] v;
    logic signed [SAT_W+3:0] hi;
    logic signed [SAT_W+3:0] lo;
    v  = {{4{x[SAT_W-1]}}, x} <<< sh;
    hi = (SAT_W+4)'((1 << (width - 1)) - 1);
    lo = ~hi;
    if (v > hi) begin
      sat_shift = hi[SAT_W-1:0];
    end else if (v < lo) begin
      sat_shift = lo[SAT_W-1:0];
    end else begin
      sat_shift = v[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/post_lna_channel.sv
// One receive/transmit channel: turnaround FSM with fixed-length guards and
// the registered, mutually exclusive receive and transmit datapaths.
module post_lna_channel
  import post_lna_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = DEFAULT_GUARD
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [WIDTH-1:0] outer_rx_i,
  input  logic [1:0]              gain_i,
  input  logic [WIDTH-1:0]        inner_tx_i,
  input  logic                    tx_req_i,
  output logic [WIDTH-1:0]        inner_rx_o,
  output logic [WIDTH-1:0]        outer_tx_o,
  output logic                    tx_ack_o,
  output logic                    busy_o,
  output logic [1:0]              state_o
);

  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);

  lna_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic             ack_q, busy_q;
  logic [WIDTH-1:0] rx_sat;

  assign rx_sat = WIDTH'(sat_shift(SAT_W'(outer_rx_i), gain_i, WIDTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RX: begin
        if (tx_req_i) begin
          state_d = RX2TX;
          cnt_d   = GUARD_LOAD;
        end
      end
      RX2TX: begin
        if (cnt_q == '0) begin
          state_d = tx_req_i ? TX : RX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX: begin
        if (!tx_req_i) begin
          state_d = TX2RX;
          cnt_d   = GUARD_LOAD;
        end
      end
      TX2RX: begin
        if (cnt_q == '0) begin
          state_d = RX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX;
    endcase
    // Data is gated by the state being entered, so a path only carries
    // samples for the cycles its state is actually held.
    rx_d = (state_d == RX) ? rx_sat : '0;
    tx_d = (state_d == TX) ? inner_tx_i : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      ack_q   <= (state_d == TX);
      busy_q  <= (state_d == RX2TX) || (state_d == TX2RX);
    end
  end

  assign inner_rx_o = rx_q;
  assign outer_tx_o = tx_q;
  assign tx_ack_o   = ack_q;
  assign busy_o     = busy_q;
  assign state_o    = state_q;

endmodule

// File: rtl/post_lna_array.sv
// Array of independent post-LNA channels; the top only slices the packed
// buses into per-channel lanes.
module post_lna_array
  import post_lna_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int GUARD    = DEFAULT_GUARD
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] OuterReceive,
  output logic [CHANNELS*WIDTH-1:0] InnerReceive,
  input  logic [CHANNELS*WIDTH-1:0] InnerTransmit,
  output logic [CHANNELS*WIDTH-1:0] OuterTransmit,
  input  logic [CHANNELS-1:0]       TxReq,
  output logic [CHANNELS-1:0]       TxAck,
  input  logic [2*CHANNELS-1:0]     GainSel,
  output logic [CHANNELS-1:0]       Busy,
  output logic [2*CHANNELS-1:0]     DbgState
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    post_lna_channel #(
      .WIDTH (WIDTH),
      .GUARD (GUARD)
    ) u_ch (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .outer_rx_i (OuterReceive[n*WIDTH +: WIDTH]),
      .gain_i     (GainSel[2*n +: 2]),
      .inner_tx_i (InnerTransmit[n*WIDTH +: WIDTH]),
      .tx_req_i   (TxReq[n]),
      .inner_rx_o (InnerReceive[n*WIDTH +: WIDTH]),
      .outer_tx_o (OuterTransmit[n*WIDTH +: WIDTH]),
      .tx_ack_o   (TxAck[n]),
      .busy_o     (Busy[n]),
      .state_o    (DbgState[2*n +: 2])
    );
  end

endmodule

// File: doc/post_lna_array.md
POST_LNA_ARRAY -- requirements
Module: post_lna_array

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent receive/transmit channel pairs (1..16).
REQ-002 Parameter WIDTH, default 8, signed two's-complement sample width per path (4..16).
REQ-003 Parameter GUARD, default 3, turnaround guard length in clock cycles (1..15).
REQ-004 Clk  input  1  single clock, all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 OuterReceive  input  CHANNELS*WIDTH  antenna-side receive samples, channel n at bits [n*WIDTH +: WIDTH].
REQ-007 InnerReceive  output  CHANNELS*WIDTH  core-side receive samples, registered.
REQ-008 InnerTransmit  input  CHANNELS*WIDTH  core-side transmit samples.
REQ-009 OuterTransmit  output  CHANNELS*WIDTH  antenna-side transmit samples, registered.
REQ-010 TxReq  input  CHANNELS  per-channel transmit request, level-sensitive.
REQ-011 TxAck  output  CHANNELS  per-channel high exactly while that channel is in TX.
REQ-012 GainSel  input  2*CHANNELS  per-channel receive gain, left shift of 0..3 bits.
REQ-013 Busy  output  CHANNELS  per-channel high while in either guard state.

Function
REQ-014 Each channel SHALL run an independent FSM with states RX, RX2TX, TX, TX2RX.
REQ-015 RX: on TxReq=1, go to RX2TX and load the guard counter with GUARD-1; otherwise stay.
REQ-016 RX2TX: decrement the counter each cycle; at 0, go to TX if TxReq=1, else to RX.
REQ-017 TX: on TxReq=0, go to TX2RX and load the guard counter with GUARD-1; otherwise stay.
REQ-018 TX2RX: decrement the counter each cycle; at 0, always go to RX. A TxReq already high is honoured from RX on the next cycle, so RX lasts at least 1 cycle.
REQ-019 Guard states SHALL always run the full GUARD cycles; TxReq changes during a guard do not shorten it.
REQ-020 In RX, InnerReceive[n] SHALL equal sat(OuterReceive[n] <<< GainSel[n]) sampled on the previous edge (1-cycle latency), and OuterTransmit[n] SHALL be 0.
REQ-021 Saturation SHALL clamp to +(2^(WIDTH-1)-1) and -(2^(WIDTH-1)), with no wrap-around.
REQ-022 In TX, OuterTransmit[n] SHALL equal InnerTransmit[n] from the previous edge (1-cycle latency), and InnerReceive[n] SHALL be 0.
REQ-023 In RX2TX and TX2RX, both InnerReceive[n] and OuterTransmit[n] SHALL be 0.
REQ-024 The same channel SHALL never drive nonzero InnerReceive and nonzero OuterTransmit in the same cycle.
REQ-025 TxAck[n] and Busy[n] SHALL be registered and decoded from the state register, with no combinational path from TxReq.
REQ-026 GainSel SHALL be sampled every cycle; a change takes effect on the next registered output.
REQ-027 Channels SHALL share no state; simultaneous requests on all channels proceed in parallel.

Reset
REQ-028 On Reset=1, every channel SHALL enter RX immediately, asynchronously and regardless of current state.
REQ-029 On Reset=1, guard counters SHALL be 0 and InnerReceive, OuterTransmit, TxAck and Busy SHALL be all zeros.
REQ-030 Reset asserted mid-guard or mid-TX SHALL abandon the transfer without completing the guard.
REQ-031 The first edge after release SHALL evaluate from RX.

Structure
REQ-032 Package post_lna_pkg SHALL hold the state enum (RX, RX2TX, TX, TX2RX), the default GUARD constant and the saturation helper function.
REQ-033 Sub-module post_lna_channel, parametrised by WIDTH and GUARD, SHALL implement one FSM and both datapaths.
REQ-034 The top level SHALL instantiate post_lna_channel CHANNELS times via a generate loop and perform only bus slicing.

Verification
REQ-035 Defaults, ch0 OuterReceive=0x10, GainSel=2 -> InnerReceive ch0=0x40 one cycle later; OuterTransmit ch0=0.
REQ-036 OuterReceive=0x50, GainSel=1 -> InnerReceive=0x7F; OuterReceive=0xA0 (-96), GainSel=1 -> InnerReceive=0x80.
REQ-037 TxReq ch1 rises at cycle 10 -> Busy ch1 high for cycles 11-13, TxAck ch1 high from cycle 14, OuterTransmit ch1 follows InnerTransmit ch1 with 1-cycle lag.
REQ-038 TxReq pulsed for 1 cycle -> full 3-cycle RX2TX guard, then RX, TxAck never asserted, all outputs 0 during the guard.
REQ-039 TxReq ch2 in TX drops, then re-rises during TX2RX -> guard completes, 1 RX cycle, then a new RX2TX guard.
REQ-040 Reset asserted during TX on all 4 channels -> all outputs 0 in the same cycle; after release TxReq=0 keeps all channels in RX.
